round_stage_arbiter: RTL and testbench

- Shares one rounding/post-normalization stage between two producers:
  - src A: pipelined add/sub/mul path (ops 0-2).
  - src B: iterative div/sqrt sequencer (ops 3, 4).
- Round-robin arbitration with valid/ready on both inputs; the rounded result is registered in a single output stage with valid/ready backpressure.
- Sits between the normalization stages and the result/writeback stage of the FPU.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/round_rne_core.sv | 42 ++++
 rtl/round_stage_arbiter.sv | 172 +++++++++++++++++
 tb/tb_round_stage_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and widths for the rounding / post-normalization stage.
// Op codes, request bundle and source identifiers used by the round-stage arbiter.
package fpu_pkg;

  localparam int EXP_W     = 10;
  localparam int NFRAC_W   = 49;
  localparam int REM_W     = 27;
  localparam int RFRAC_W   = 25;
  // Tag field in the request bundle is sized for the widest tag a client may use.
  localparam int TAG_MAX_W = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4
  } op_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic [2:0]           op;
    logic [EXP_W-1:0]     exponent;
    logic [NFRAC_W-1:0]   fraction;
    logic [REM_W-1:0]     remainder;
    logic [TAG_MAX_W-1:0] tag;
  } round_req_t;

  // Div/sqrt carry their discarded bits in the remainder, not in the fraction tail.
  function automatic logic uses_remainder_sticky(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_SQRT);
  endfunction

endpackage

// File: rtl/round_rne_core.sv
// Combinational round-to-nearest-even of a 2.47 fraction down to 2.23,
// followed by a one-bit post-normalization shift with exponent increment.
module round_rne_core
  import fpu_pkg::*;
(
  input  logic [2:0]         op,
  input  logic [EXP_W-1:0]   exponent,
  input  logic [NFRAC_W-1:0] fraction,
  input  logic [REM_W-1:0]   remainder,
  output logic [EXP_W-1:0]   rnd_exponent,
  output logic [RFRAC_W-1:0] rnd_fraction
);

  logic               lsb_bit;
  logic               guard_bit;
  logic               round_bit;
  logic               sticky_bit;
  logic               round_up;
  logic [RFRAC_W-1:0] rounded;
  // The top integer bit is never set on a normalized input, so only [47:0] matter.
  logic               unused_int_bit;

  assign unused_int_bit = fraction[NFRAC_W-1];

  assign lsb_bit    = fraction[24];
  assign guard_bit  = fraction[23];
  assign round_bit  = fraction[22];
  assign sticky_bit = uses_remainder_sticky(op) ? (|remainder) : (|fraction[21:0]);
  assign round_up   = guard_bit && (round_bit || sticky_bit || lsb_bit);

  assign rounded = {1'b0, fraction[47:24]} + {{(RFRAC_W-1){1'b0}}, round_up};

  always_comb begin
    rnd_fraction = rounded;
    rnd_exponent = exponent;
    if (rounded[RFRAC_W-1]) begin
      rnd_fraction = rounded >> 1;
      rnd_exponent = exponent + {{(EXP_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/round_stage_arbiter.sv
// Round-robin arbiter sharing one RNE rounding stage between the pipelined
// add/sub/mul path (src A) and the div/sqrt sequencer (src B); registered output.
// Optional performance counters are built when ROUND_ARB_PERF_CNT_EN is defined.
module round_stage_arbiter
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [2:0]           a_op,
  input  logic [EXP_W-1:0]     a_exponent,
  input  logic [NFRAC_W-1:0]   a_fraction,
  input  logic [REM_W-1:0]     a_remainder,
  input  logic [TAG_W-1:0]     a_tag,

  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [2:0]           b_op,
  input  logic [EXP_W-1:0]     b_exponent,
  input  logic [NFRAC_W-1:0]   b_fraction,
  input  logic [REM_W-1:0]     b_remainder,
  input  logic [TAG_W-1:0]     b_tag,

`ifdef ROUND_ARB_PERF_CNT_EN
  output logic [31:0]          perf_grant_a,
  output logic [31:0]          perf_grant_b,
  output logic [31:0]          perf_stall,
`endif

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W-1:0]     out_exponent,
  output logic [RFRAC_W-1:0]   out_fraction,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_src
);

  round_req_t         req [2];
  round_req_t         sel_req;
  logic [1:0]         req_valid;
  logic [1:0]         grant_vec;
  logic [1:0]         ready_vec;
  logic               load_en;
  logic               accept;
  src_e               rr_ptr_reg;
  src_e               rr_ptr_next;

  logic               out_valid_reg;
  logic [EXP_W-1:0]   out_exponent_reg;
  logic [RFRAC_W-1:0] out_fraction_reg;
  logic [TAG_W-1:0]   out_tag_reg;
  logic               out_src_reg;

  logic [EXP_W-1:0]   rnd_exponent;
  logic [RFRAC_W-1:0] rnd_fraction;
  // Bits of the wide tag field above TAG_W are always zero.
  logic [TAG_MAX_W-1:0] unused_tag;

  always_comb begin
    req[0]           = '0;
    req[0].op        = a_op;
    req[0].exponent  = a_exponent;
    req[0].fraction  = a_fraction;
    req[0].remainder = a_remainder;
    req[0].tag       = TAG_MAX_W'(a_tag);
    req[1]           = '0;
    req[1].op        = b_op;
    req[1].exponent  = b_exponent;
    req[1].fraction  = b_fraction;
    req[1].remainder = b_remainder;
    req[1].tag       = TAG_MAX_W'(b_tag);
  end

  assign req_valid = {b_valid, a_valid};
  assign load_en   = !out_valid_reg || out_ready;

  // A lone requester always wins; a tie goes to whichever source rr_ptr names.
  assign grant_vec[0] = req_valid[0] && (!req_valid[1] || (rr_ptr_reg == SRC_A));
  assign grant_vec[1] = req_valid[1] && (!req_valid[0] || (rr_ptr_reg == SRC_B));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = load_en && grant_vec[gi];
    end
  endgenerate

  assign a_ready = ready_vec[0];
  assign b_ready = ready_vec[1];
  assign accept  = |ready_vec;

  assign sel_req    = grant_vec[1] ? req[1] : req[0];
  assign unused_tag = sel_req.tag;

  round_rne_core u_round_rne_core (
    .op           (sel_req.op),
    .exponent     (sel_req.exponent),
    .fraction     (sel_req.fraction),
    .remainder    (sel_req.remainder),
    .rnd_exponent (rnd_exponent),
    .rnd_fraction (rnd_fraction)
  );

  // After a grant the other source gets priority on the next tie.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      rr_ptr_next = grant_vec[0] ? SRC_B : SRC_A;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg       <= SRC_A;
      out_valid_reg    <= 1'b0;
      out_exponent_reg <= '0;
      out_fraction_reg <= '0;
      out_tag_reg      <= '0;
      out_src_reg      <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (accept) begin
        out_valid_reg    <= 1'b1;
        out_exponent_reg <= rnd_exponent;
        out_fraction_reg <= rnd_fraction;
        out_tag_reg      <= sel_req.tag[TAG_W-1:0];
        out_src_reg      <= grant_vec[1];
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_exponent = out_exponent_reg;
  assign out_fraction = out_fraction_reg;
  assign out_tag      = out_tag_reg;
  assign out_src      = out_src_reg;

`ifdef ROUND_ARB_PERF_CNT_EN
  logic [31:0] perf_grant_reg [2];
  logic [31:0] perf_stall_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_grant
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          perf_grant_reg[gi] <= '0;
        end else if (ready_vec[gi]) begin
          perf_grant_reg[gi] <= perf_grant_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_reg <= '0;
    end else if ((|req_valid) && !load_en) begin
      perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_grant_a = perf_grant_reg[0];
  assign perf_grant_b = perf_grant_reg[1];
  assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_round_stage_arbiter.sv
// Directed self-checking bench for round_stage_arbiter: rounding cases,
// round-robin ordering, output backpressure hold and asynchronous reset.
module tb_round_stage_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [2:0]  a_op, b_op;
  logic [9:0]  a_exponent, b_exponent;
  logic [48:0] a_fraction, b_fraction;
  logic [26:0] a_remainder, b_remainder;
  logic [3:0]  a_tag, b_tag;
  logic        out_valid, out_ready, out_src;
  logic [9:0]  out_exponent;
  logic [24:0] out_fraction;
  logic [3:0]  out_tag;
`ifdef ROUND_ARB_PERF_CNT_EN
  logic [31:0] perf_grant_a, perf_grant_b, perf_stall;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  round_stage_arbiter #(.TAG_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_op         (a_op),
    .a_exponent   (a_exponent),
    .a_fraction   (a_fraction),
    .a_remainder  (a_remainder),
    .a_tag        (a_tag),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_op         (b_op),
    .b_exponent   (b_exponent),
    .b_fraction   (b_fraction),
    .b_remainder  (b_remainder),
    .b_tag        (b_tag),
`ifdef ROUND_ARB_PERF_CNT_EN
    .perf_grant_a (perf_grant_a),
    .perf_grant_b (perf_grant_b),
    .perf_stall   (perf_stall),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_exponent (out_exponent),
    .out_fraction (out_fraction),
    .out_tag      (out_tag),
    .out_src      (out_src)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [9:0] exp_v, input logic [23:0] hi,
                         input logic [23:0] lo, input logic [26:0] rem, input logic [3:0] tag);
    a_valid = 1'b1; a_op = op; a_exponent = exp_v;
    a_fraction = {1'b0, hi, lo}; a_remainder = rem; a_tag = tag;
  endtask

  task automatic drive_b(input logic [2:0] op, input logic [9:0] exp_v, input logic [23:0] hi,
                         input logic [23:0] lo, input logic [26:0] rem, input logic [3:0] tag);
    b_valid = 1'b1; b_op = op; b_exponent = exp_v;
    b_fraction = {1'b0, hi, lo}; b_remainder = rem; b_tag = tag;
  endtask

  // Called at a falling edge; presents one request from a single source and checks the result.
  task automatic run_single(input string name, input logic is_b, input logic [2:0] op,
                            input logic [9:0] exp_v, input logic [23:0] hi, input logic [23:0] lo,
                            input logic [26:0] rem, input logic [3:0] tag,
                            input logic [24:0] want_frac, input logic [9:0] want_exp);
    if (is_b) drive_b(op, exp_v, hi, lo, rem, tag);
    else      drive_a(op, exp_v, hi, lo, rem, tag);
    #1;
    check($sformatf("%s.a_ready", name), a_ready, !is_b);
    check($sformatf("%s.b_ready", name), b_ready, is_b);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    check($sformatf("%s.valid", name), out_valid, 1'b1);
    check($sformatf("%s.frac", name), out_fraction, want_frac);
    check($sformatf("%s.exp", name), out_exponent, want_exp);
    check($sformatf("%s.src", name), out_src, is_b);
    check($sformatf("%s.tag", name), out_tag, tag);
    $display("[TB] %s: src=%0d op=%0d frac=%h exp=%0d", name, is_b, op, out_fraction, out_exponent);
  endtask

  initial begin
    reset_n = 1'b0;
    a_valid = 1'b0; a_op = '0; a_exponent = '0; a_fraction = '0; a_remainder = '0; a_tag = '0;
    b_valid = 1'b0; b_op = '0; b_exponent = '0; b_fraction = '0; b_remainder = '0; b_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid", out_valid, 1'b0);
    check("rst.frac", out_fraction, 25'h0);
    check("rst.exp", out_exponent, 10'd0);
    check("rst.tag", out_tag, 4'h0);
    check("rst.src", out_src, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    run_single("tie_even",    1'b0, 3'd0, 10'd127,  24'h800000, 24'h800000, 27'h0, 4'h1, 25'h0800000, 10'd127);
    run_single("carry_out",   1'b0, 3'd0, 10'd127,  24'hFFFFFF, 24'hC00000, 27'h0, 4'h2, 25'h0800000, 10'd128);
    run_single("exp_wrap",    1'b0, 3'd1, 10'd1023, 24'hFFFFFF, 24'hC00000, 27'h0, 4'h3, 25'h0800000, 10'd0);
    run_single("div_rem",     1'b1, 3'd3, 10'd127,  24'h800000, 24'h800000, 27'h1, 4'h4, 25'h0800001, 10'd127);
    run_single("b_op0_rem",   1'b1, 3'd0, 10'd127,  24'h800000, 24'h800000, 27'h1, 4'h5, 25'h0800000, 10'd127);
    run_single("op5_rem",     1'b0, 3'd5, 10'd127,  24'h800000, 24'h800000, 27'h1, 4'h6, 25'h0800000, 10'd127);
    run_single("mul_sticky",  1'b0, 3'd2, 10'd127,  24'h800000, 24'h800001, 27'h0, 4'h7, 25'h0800001, 10'd127);
    run_single("sqrt_nostk",  1'b1, 3'd4, 10'd127,  24'h800000, 24'h800001, 27'h0, 4'h8, 25'h0800000, 10'd127);

    // Both sources held valid: grants must alternate A, B, A, B.
    drive_a(3'd0, 10'd127, 24'h123456, 24'h000000, 27'h0, 4'h1);
    drive_b(3'd3, 10'd200, 24'h400001, 24'h800000, 27'h0, 4'h2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d.a_ready", i), a_ready, (i % 2) == 0);
      check($sformatf("rr%0d.b_ready", i), b_ready, (i % 2) == 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rr%0d.src", i), out_src, (i % 2) == 1);
      check($sformatf("rr%0d.frac", i), out_fraction, ((i % 2) == 1) ? 25'h0400002 : 25'h0123456);
      check($sformatf("rr%0d.exp", i), out_exponent, ((i % 2) == 1) ? 10'd200 : 10'd127);
      $display("[TB] rr%0d: src=%0d frac=%h exp=%0d", i, out_src, out_fraction, out_exponent);
    end
    b_valid = 1'b0;

    // Backpressure: the src B result must hold while A waits.
    out_ready = 1'b0;
    drive_a(3'd0, 10'd10, 24'h800000, 24'hC00000, 27'h0, 4'h5);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold%0d.a_ready", i), a_ready, 1'b0);
      check($sformatf("hold%0d.b_ready", i), b_ready, 1'b0);
      check($sformatf("hold%0d.valid", i), out_valid, 1'b1);
      check($sformatf("hold%0d.frac", i), out_fraction, 25'h0400002);
      check($sformatf("hold%0d.exp", i), out_exponent, 10'd200);
      check($sformatf("hold%0d.tag", i), out_tag, 4'h2);
      check($sformatf("hold%0d.src", i), out_src, 1'b1);
      $display("[TB] hold%0d: valid=%0d frac=%h", i, out_valid, out_fraction);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release.a_ready", a_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    check("release.frac", out_fraction, 25'h0800001);
    check("release.exp", out_exponent, 10'd10);
    check("release.tag", out_tag, 4'h5);
    check("release.src", out_src, 1'b0);
    $display("[TB] release: src=%0d frac=%h exp=%0d", out_src, out_fraction, out_exponent);

    // Asynchronous reset while a result is held; rr_ptr currently prefers B.
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.valid", out_valid, 1'b0);
    check("async_rst.frac", out_fraction, 25'h0);
    check("async_rst.exp", out_exponent, 10'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive_a(3'd0, 10'd5, 24'h000010, 24'h000000, 27'h0, 4'h9);
    drive_b(3'd0, 10'd6, 24'h000020, 24'h000000, 27'h0, 4'hA);
    #1;
    check("post_rst.a_ready", a_ready, 1'b1);
    check("post_rst.b_ready", b_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("post_rst.valid", out_valid, 1'b1);
    check("post_rst.src", out_src, 1'b0);
    check("post_rst.tag", out_tag, 4'h9);
    $display("[TB] post_rst: src=%0d tag=%0h", out_src, out_tag);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
